// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory stage: MMIO register offsets, status bit
// positions and the access-target decode type.
package dmem_mmio_pkg;

  localparam logic [3:0] OffLed = 4'h0;
  localparam logic [3:0] OffCyc = 4'h4;
  localparam logic [3:0] OffTx  = 4'h8;
  localparam logic [3:0] OffCnt = 4'hC;

  localparam int unsigned StatEmptyBit = 0;
  localparam int unsigned StatFullBit  = 1;
  localparam int unsigned StatOvfBit   = 2;

  typedef enum logic [2:0] {
    SelNone,
    SelRam,
    SelLed,
    SelCyc,
    SelTx,
    SelCnt
  } sel_e;

endpackage

// File: rtl/dmem_mmio_con_fifo.sv
// Console TX FIFO: registered storage and head, push/pop handshake, and a sticky
// overflow flag for bytes dropped while full.
module dmem_mmio_con_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [7:0]                 push_data_i,
  input  logic                       ready_i,
  input  logic                       ovf_clr_i,
  output logic                       valid_o,
  output logic [7:0]                 data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ovf_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [7:0]    mem_q [Depth];
  logic [Aw-1:0] rd_ptr_q, wr_ptr_q;
  logic [Aw:0]   count_q;
  logic          ovf_q;
  logic          pop, accept, drop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (Aw + 1)'(Depth));
  assign pop     = !empty_o && ready_i;
  // A full FIFO still takes a byte if the head leaves on the same edge.
  assign accept  = push_i && (!full_o || pop);
  assign drop    = push_i && !accept;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + Aw'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + Aw'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + (Aw + 1)'(1);
        2'b01:   count_q <= count_q - (Aw + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign valid_o = !empty_o;
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
  assign ovf_o   = ovf_q;
  assign count_o = count_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory stage: word RAM plus MMIO (LED, free-running cycle counter,
// console TX FIFO). Loads are combinational, stores commit on the rising edge.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = 32'h1001_0000,
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        dm_r,
  input  logic        dm_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic [15:0] led,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      ram_off, mmio_off;
  logic [RamAw-1:0] ram_idx;
  sel_e             sel;
  logic             wr_en;
  logic [15:0]      led_q;
  logic [31:0]      cyc_q;
  logic             fifo_full, fifo_empty, fifo_ovf;
  logic [CntW-1:0]  fifo_count;
  logic [31:0]      status;

  assign ram_off  = addr - RAM_BASE;
  assign mmio_off = addr - MMIO_BASE;
  assign ram_idx  = ram_off[RamAw+1:2];

  always_comb begin
    sel = SelNone;
    if (addr[1:0] == 2'b00) begin
      if ((addr >= RAM_BASE) && (ram_off < RAM_WORDS * 4)) begin
        sel = SelRam;
      end else if (mmio_off[31:4] == 28'h0) begin
        case (mmio_off[3:0])
          OffLed:  sel = SelLed;
          OffCyc:  sel = SelCyc;
          OffTx:   sel = SelTx;
          OffCnt:  sel = SelCnt;
          default: sel = SelNone;
        endcase
      end
    end
  end

  // Errors are only reported for an actual access attempt.
  assign bus_err = cs && (dm_r || dm_w) && ((dm_r && dm_w) || (sel == SelNone));
  assign wr_en   = cs && dm_w && !dm_r && !bus_err && !rst;

  always_ff @(posedge clk) begin
    if (wr_en && (sel == SelRam)) begin
      ram[ram_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 16'h0000;
      cyc_q <= 32'h0;
    end else begin
      if (wr_en && (sel == SelLed)) led_q <= wdata[15:0];
      cyc_q <= (wr_en && (sel == SelCyc)) ? 32'h0 : cyc_q + 32'h1;
    end
  end

  dmem_mmio_con_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_con_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (wr_en && (sel == SelTx)),
    .push_data_i (wdata[7:0]),
    .ready_i     (con_ready),
    .ovf_clr_i   (wr_en && (sel == SelCnt)),
    .valid_o     (con_valid),
    .data_o      (con_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .ovf_o       (fifo_ovf),
    .count_o     (fifo_count)
  );

  always_comb begin
    status               = 32'h0;
    status[StatEmptyBit] = fifo_empty;
    status[StatFullBit]  = fifo_full;
    status[StatOvfBit]   = fifo_ovf;
  end

  always_comb begin
    rdata = 32'h0;
    if (cs && dm_r && !bus_err) begin
      case (sel)
        SelRam:  rdata = ram[ram_idx];
        SelLed:  rdata = {16'h0000, led_q};
        SelCyc:  rdata = cyc_q;
        SelTx:   rdata = status;
        SelCnt:  rdata = 32'(fifo_count);
        default: rdata = 32'h0;
      endcase
    end
  end

  assign led = led_q;

endmodule
